mem_port_arb: RTL

//   Arbitrates the single external memory port between instruction fetch (IF) and the

---
 rtl/mem_port_arb.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mem_port_arb.sv
// Single-outstanding arbiter for the external memory port: data requests win over fetch,
// with a consecutive-win limit so a waiting fetch cannot starve.
module mem_port_arb #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int DM_MAX_CONSEC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_if_req,
  input  logic [AW-1:0]   i_if_addr,
  input  logic            i_if_flush,
  output logic            o_if_gnt,
  output logic            o_if_rvld,
  output logic [DW-1:0]   o_if_rdata,
  input  logic            i_dm_req,
  input  logic            i_dm_we,
  input  logic [DW/8-1:0] i_dm_be,
  input  logic [AW-1:0]   i_dm_addr,
  input  logic [DW-1:0]   i_dm_wdata,
  output logic            o_dm_gnt,
  output logic            o_dm_rvld,
  output logic [DW-1:0]   o_dm_rdata,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [DW/8-1:0] o_mem_be,
  output logic [AW-1:0]   o_mem_addr,
  output logic [DW-1:0]   o_mem_wdata,
  input  logic            i_mem_gnt,
  input  logic            i_mem_rvld,
  input  logic [DW-1:0]   i_mem_rdata,
  output logic            o_busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RSP  = 2'd2;

  localparam int              CW      = $clog2(DM_MAX_CONSEC + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DM_MAX_CONSEC);
  localparam logic            OWN_IF  = 1'b0;
  localparam logic            OWN_DM  = 1'b1;

  logic [1:0]    state;
  logic          owner;
  logic          drop;
  logic [CW-1:0] cnt;
  logic          dm_win;
  logic          if_win;
  logic          if_owns;

  // Fetch only takes the port once data has won DM_MAX_CONSEC times in a row over it.
  assign dm_win  = i_dm_req && !(i_if_req && (cnt == CNT_MAX));
  assign if_win  = i_if_req && !dm_win;
  assign if_owns = (owner == OWN_IF);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= OWN_IF;
      cnt         <= '0;
      drop        <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_be    <= '0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          drop <= 1'b0;
          if (dm_win) begin
            state       <= REQ;
            owner       <= OWN_DM;
            o_mem_we    <= i_dm_we;
            o_mem_be    <= i_dm_be;
            o_mem_addr  <= i_dm_addr;
            o_mem_wdata <= i_dm_wdata;
            if (!i_if_req)
              cnt <= '0;
            else if (cnt != CNT_MAX)
              cnt <= cnt + CW'(1);
          end else if (if_win && !i_if_flush) begin
            // A fetch flushed in the very cycle it would win never reaches the bus.
            state       <= REQ;
            owner       <= OWN_IF;
            o_mem_we    <= 1'b0;
            o_mem_be    <= '1;
            o_mem_addr  <= i_if_addr;
            o_mem_wdata <= '0;
            cnt         <= '0;
          end
        end
        REQ: begin
          if (if_owns && i_if_flush) drop <= 1'b1;
          if (i_mem_gnt) state <= RSP;
        end
        RSP: begin
          if (i_mem_rvld) begin
            state <= IDLE;
            drop  <= 1'b0;
          end else if (if_owns && i_if_flush) begin
            drop <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A flushed fetch still completes on the bus; only its handshakes to fetch are hidden.
  assign o_mem_req  = (state == REQ);
  assign o_busy     = (state != IDLE);
  assign o_if_gnt   = o_mem_req && i_mem_gnt && if_owns && !drop && !i_if_flush;
  assign o_dm_gnt   = o_mem_req && i_mem_gnt && !if_owns;
  assign o_if_rvld  = (state == RSP) && i_mem_rvld && if_owns && !drop && !i_if_flush;
  assign o_dm_rvld  = (state == RSP) && i_mem_rvld && !if_owns;
  assign o_if_rdata = ((state == RSP) && if_owns)  ? i_mem_rdata : '0;
  assign o_dm_rdata = ((state == RSP) && !if_owns) ? i_mem_rdata : '0;

endmodule
